// File: rtl/mem_loader_pkg.sv
// Shared CPU definitions: instruction memory constants and loader state encoding.
package mem_loader_pkg;

  localparam int unsigned DEF_MEM_BYTES   = 100;
  localparam int unsigned IMEM_WORD_BYTES = 4;
  localparam int unsigned IMEM_ADDR_W     = 32;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StWrite,
    StDone
  } ld_state_e;

endpackage

// File: rtl/mem_loader_byte_packer.sv
// Packs arriving bytes big-endian into a 32-bit word; unfilled bytes stay zero.
module mem_loader_byte_packer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic        i_last,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_full,
  output logic        o_word_done
);

  logic [1:0]  r_idx;
  logic [31:0] r_word;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_clear) begin
      r_idx  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_accept) begin
      unique case (r_idx)
        2'd0: r_word[31:24] <= i_byte;
        2'd1: r_word[23:16] <= i_byte;
        2'd2: r_word[15:8]  <= i_byte;
        2'd3: r_word[7:0]   <= i_byte;
        default: r_word <= r_word;
      endcase
      r_idx <= r_idx + 2'd1;
    end
  end

  assign o_word      = r_word;
  assign o_full      = (r_idx == 2'd3);
  // A word is complete when its 4th byte or the load's final byte is accepted.
  assign o_word_done = i_accept && (o_full || i_last);

endmodule

// File: rtl/mem_loader.sv
// Loads a program byte stream into instruction memory as big-endian words.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned MEM_BYTES = DEF_MEM_BYTES
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic [7:0]             LoadLen,
  input  logic [7:0]             ByteIn,
  input  logic                   ByteValid,
  output logic                   ByteReady,
  output logic                   InsMemWr,
  output logic [IMEM_ADDR_W-1:0] WrAddr,
  output logic [31:0]            WrData,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Err
);

  ld_state_e              r_state;
  ld_state_e              w_state_d;
  logic [7:0]             r_len;
  logic [7:0]             r_cnt;
  logic [IMEM_ADDR_W-1:0] r_addr;
  logic                   r_err;

  logic        w_can_start;
  logic        w_start_zero;
  logic        w_start_rej;
  logic        w_start_ok;
  logic        w_accept;
  logic        w_last;
  logic        w_clear;
  logic        w_full;
  logic        w_word_done;
  logic [31:0] w_word;

  assign w_can_start  = Start && ((r_state == StIdle) || (r_state == StDone));
  assign w_start_zero = w_can_start && (LoadLen == 8'd0);
  assign w_start_rej  = w_can_start && (32'(LoadLen) > MEM_BYTES);
  assign w_start_ok   = w_can_start && (LoadLen != 8'd0) && (32'(LoadLen) <= MEM_BYTES);
  assign w_accept     = ByteValid && (r_state == StCollect);
  assign w_last       = ((r_cnt + 8'd1) == r_len);
  assign w_clear      = w_start_ok || (r_state == StWrite);

  mem_loader_byte_packer u_packer (
    .i_clk       (CLK),
    .i_rst_n     (Reset),
    .i_clear     (w_clear),
    .i_accept    (w_accept),
    .i_last      (w_last),
    .i_byte      (ByteIn),
    .o_word      (w_word),
    .o_full      (w_full),
    .o_word_done (w_word_done)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle, StDone: begin
        if (w_start_zero)     w_state_d = StDone;
        else if (w_start_rej) w_state_d = StIdle;
        else if (w_start_ok)  w_state_d = StCollect;
      end
      StCollect: if (w_word_done) w_state_d = StWrite;
      StWrite:   w_state_d = (r_cnt == r_len) ? StDone : StCollect;
      default:   w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state <= StIdle;
      r_len   <= 8'd0;
      r_cnt   <= 8'd0;
      r_addr  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_start_ok || w_start_zero) begin
        r_err  <= 1'b0;
        r_cnt  <= 8'd0;
        r_len  <= LoadLen;
        r_addr <= '0;
      end else if (w_start_rej) begin
        r_err <= 1'b1;
      end
      if (w_accept) r_cnt <= r_cnt + 8'd1;
      if (r_state == StWrite) r_addr <= r_addr + IMEM_ADDR_W'(IMEM_WORD_BYTES);
    end
  end

  assign ByteReady = (r_state == StCollect);
  assign InsMemWr  = (r_state == StWrite);
  assign WrAddr    = r_addr;
  assign WrData    = w_word;
  assign Busy      = (r_state == StCollect) || (r_state == StWrite);
  assign Done      = (r_state == StDone);
  assign Err       = r_err;

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter: MEM_BYTES, default 100, instruction memory size in bytes.
REQ-002 Port: CLK  input  1  system clock; all state changes on rising edge.
REQ-003 Port: Reset  input  1  asynchronous reset, active-low (0 = reset).
REQ-004 Port: Start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-005 Port: LoadLen  input  8  number of bytes to load; sampled with Start.
REQ-006 Port: ByteIn  input  8  incoming program byte.
REQ-007 Port: ByteValid  input  1  ByteIn holds a valid byte.
REQ-008 Port: ByteReady  output  1  loader accepts a byte this cycle.
REQ-009 Port: InsMemWr  output  1  one-cycle word write strobe to the instruction memory.
REQ-010 Port: WrAddr  output  32  byte address of the word being written; always a multiple of 4.
REQ-011 Port: WrData  output  32  word being written, big-endian.
REQ-012 Port: Busy  output  1  a load is in progress; the CPU is stalled while high.
REQ-013 Port: Done  output  1  the last load completed successfully.
REQ-014 Port: Err  output  1  the last Start was rejected.

Function
REQ-015 The FSM SHALL have four states: IDLE, COLLECT, WRITE and DONE.
REQ-016 IDLE, Start=1, LoadLen=0: go to DONE, no write, Err=0.
REQ-017 IDLE, Start=1, LoadLen>MEM_BYTES: stay in IDLE, set Err=1 and Done=0, no write.
REQ-018 IDLE, Start=1, 0<LoadLen<=MEM_BYTES: go to COLLECT, clear Err, Done and the byte counter, latch LoadLen.
REQ-019 ByteReady SHALL be 1 only in COLLECT; a byte is accepted on a cycle where ByteValid and ByteReady are both 1.
REQ-020 Byte k of a word (k=0..3 in arrival order) SHALL fill WrData bits [31-8k:24-8k]; the first byte lands in [31:24].
REQ-021 After the 4th byte of a word, or after the final byte (count==LoadLen), go to WRITE on the next edge.
REQ-022 Write latency: InsMemWr SHALL be 1 for exactly one cycle, the cycle after the accepting edge, with WrAddr and WrData stable in that cycle.
REQ-023 A partial final word (LoadLen mod 4 != 0) SHALL have its unfilled low-order bytes set to 0x00.
REQ-024 WrAddr SHALL be 4 times the word index, starting at 0; the address never wraps, because LoadLen<=MEM_BYTES.
REQ-025 WRITE SHALL return to COLLECT if bytes remain, else go to DONE; the word register SHALL be cleared on leaving WRITE.
REQ-026 In DONE, Done=1 and Busy=0, held until the next accepted Start, which is handled as from IDLE.
REQ-027 Busy SHALL be 1 in COLLECT and WRITE only.
REQ-028 Start while Busy=1 SHALL be ignored.
REQ-029 ByteValid with no acceptance SHALL not change any state.
REQ-030 Stalls are unbounded: there is no timeout.

Reset
REQ-031 Reset=0 SHALL immediately force IDLE, with ByteReady=0, InsMemWr=0, WrAddr=0, WrData=0, Busy=0, Done=0, Err=0 and counters=0.
REQ-032 Reset during COLLECT or WRITE SHALL abandon the load; words already written stay in memory, and no further strobe is issued.
REQ-033 On release of reset the loader SHALL leave IDLE only on a fresh Start.

Structure
REQ-034 The state encoding and MEM_BYTES default SHALL live in the shared CPU definitions package, alongside the instruction memory constants.
REQ-035 One sub-module, byte_packer, is natural: it holds the byte index, shift-in of big-endian bytes, zero-pad and full/last flags.
REQ-036 The FSM, the address counter and the handshake SHALL remain in mem_loader.
REQ-037 The write port SHALL match the instruction memory byte layout, so that a later 4-byte big-endian read at WrAddr returns WrData.

Verification
REQ-038 LoadLen=8, bytes 0x20,0x01,0x00,0x05,0xAC,0x02,0x00,0x04, ByteValid always 1 -> two strobes: (0x00, 0x20010005) then (0x04, 0xAC020004); Done=1; Busy=1 for 10 cycles.
REQ-039 LoadLen=6, bytes 0x11..0x16 -> strobes (0x00, 0x11121314) and (0x04, 0x15160000); Done=1.
REQ-040 LoadLen=4 with ByteValid toggling 1,0,0,1,1,0,1 -> one strobe (0x00, word of the 4 accepted bytes); no strobe during gaps; ByteReady=1 throughout COLLECT.
REQ-041 LoadLen=101 -> Err=1, Busy=0, no strobe; then LoadLen=0 -> Done=1, Err=0, no strobe.
REQ-042 Reset=0 asserted after 5 of 8 bytes -> outputs zero in the same cycle, one strobe total; after release, Start with LoadLen=4 -> strobe at WrAddr=0x00.
REQ-043 Start pulsed mid-load -> ignored; address sequence unchanged.
